// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch sequencer. It presents the current PC
// to instruction memory, latches the returned word into the instruction
// register (IR), exposes the opcode to the control unit for one EXEC cycle,
// and then applies the control unit's PCWre/PCSrc decision to advance the
// PC or halt.
//
// Ports:
//   CLK          in   1   system clock, rising-edge active
//   Reset        in   1   synchronous active-high reset
//   instr_req    out  1   fetch request (high in FETCH)
//   instr_addr   out  32  fetch address (equals pc)
//   instr_rdata  in   32  instruction word from memory
//   instr_valid  in   1   instr_rdata valid, sampled only in FETCH
//   instr        out  32  instruction register
//   op           out  6   instr[31:26] for the control unit
//   ir_valid     out  1   high for exactly the EXEC cycle
//   PCWre        in   1   0 = halt, 1 = advance PC (sampled in EXEC)
//   PCSrc        in   1   1 = take branch (sampled in EXEC)
//   imm          in   16  branch word offset (sampled in EXEC)
//   Jump         in   1   jump request (only with FETCH_JUMP_EN)
//   pc           out  32  current PC
//   halted       out  1   sticky halt indication
//   retired      out  32  instructions completed with PCWre=1 (wraps)
//
// Configuration macro:
//   FETCH_JUMP_EN  when defined, an EXEC cycle with PCWre=1 and Jump=1 loads
//                  PC with {(PC+4)[31:28], instr[25:0], 2'b00}; Jump has
//                  priority over PCSrc. When undefined, Jump is ignored.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        instr_req,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_rdata,
    input  logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        ir_valid,
    input  logic        PCWre,
    input  logic        PCSrc,
    input  logic [15:0] imm,
    input  logic        Jump,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired
);

    // PC is always word aligned, including the reset value.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    // -------------------------------------------------------------------------
    // Next-PC candidates. All arithmetic is 32-bit and wraps naturally.
    // -------------------------------------------------------------------------
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] pc_branch;
    logic [31:0] pc_next;

    assign pc_plus4   = pc_q + 32'd4;
    // Sign-extended word offset, already shifted to a byte offset.
    assign branch_off = {{14{imm[15]}}, imm, 2'b00};
    assign pc_branch  = pc_plus4 + branch_off;

`ifdef FETCH_JUMP_EN
    logic [31:0] pc_jump;

    // Region-relative jump: keep the top nibble of the sequential PC.
    assign pc_jump = {pc_plus4[31:28], ir_q[25:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        if (Jump) begin
            pc_next = pc_jump;
        end else if (PCSrc) begin
            pc_next = pc_branch;
        end
    end
`else
    // Jump is part of the port list in every build but has no function here.
    logic unused_jump;
    assign unused_jump = Jump;

    always_comb begin
        pc_next = pc_plus4;
        if (PCSrc) begin
            pc_next = pc_branch;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. Inputs are only consulted in the state that owns them:
    // instr_valid in FETCH, PCWre/PCSrc/imm/Jump in EXEC.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_rdata;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (PCWre) begin
                    pc_d      = pc_next;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end else begin
                    // PC and retire count freeze at the halting instruction.
                    state_d = S_HALT;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                // Unused encoding: recover by refetching at the current PC.
                state_d = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. Reset wins over everything, so a memory response that
    // lands on the reset cycle is dropped along with the outstanding fetch.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC_ALIGNED;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded purely from registered state, no input-to-output paths.
    // -------------------------------------------------------------------------
    assign instr_req  = (state_q == S_FETCH);
    assign instr_addr = pc_q;
    assign ir_valid   = (state_q == S_EXEC);
    assign halted     = (state_q == S_HALT);
    assign instr      = ir_q;
    assign op         = ir_q[31:26];
    assign pc         = pc_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed plus randomized bench for pc_fetch_unit. Two instances are built:
// dut_a with the default reset PC and dut_b with RESET_PC = 32'hFFFF_FFFC.
// Both share the stimulus; the one not under test is held in reset. A small
// transaction-level model (pc, IR, retire count, halt flag) supplies every
// expected value.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

`ifdef FETCH_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        PCWre, PCSrc, Jump;
    logic [15:0] imm;

    logic        req_a, req_b, irv_a, irv_b, hlt_a, hlt_b;
    logic [31:0] addr_a, addr_b, instr_a, instr_b, pc_a, pc_b, ret_a, ret_b;
    logic [5:0]  op_a, op_b;

    pc_fetch_unit dut_a (
        .CLK(clk), .Reset(rst_a),
        .instr_req(req_a), .instr_addr(addr_a),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .instr(instr_a), .op(op_a), .ir_valid(irv_a),
        .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm), .Jump(Jump),
        .pc(pc_a), .halted(hlt_a), .retired(ret_a)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .CLK(clk), .Reset(rst_b),
        .instr_req(req_b), .instr_addr(addr_b),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid),
        .instr(instr_b), .op(op_b), .ir_valid(irv_b),
        .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm), .Jump(Jump),
        .pc(pc_b), .halted(hlt_b), .retired(ret_b)
    );

    // Observed signals of the instance under test.
    bit          sel = 1'b0;
    logic        o_req, o_irv, o_hlt;
    logic [31:0] o_addr, o_instr, o_pc, o_ret;
    logic [5:0]  o_op;

    assign o_req   = sel ? req_b   : req_a;
    assign o_irv   = sel ? irv_b   : irv_a;
    assign o_hlt   = sel ? hlt_b   : hlt_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_instr = sel ? instr_b : instr_a;
    assign o_pc    = sel ? pc_b    : pc_a;
    assign o_ret   = sel ? ret_b   : ret_a;
    assign o_op    = sel ? op_b    : op_a;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc, m_ir, m_ret;
    bit          m_halt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ir,
                                               input bit src, input logic [15:0] im, input bit jmp);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (JUMP_EN && jmp)
            return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
        if (src)
            return seq + 32'(int'($signed(im)) * 4);
        return seq;
    endfunction

    task automatic do_reset(input bit s);
        sel = s;
        rst_a = 1'b1;
        rst_b = 1'b1;
        instr_valid = 1'b1;          // a response on the reset edge must be dropped
        instr_rdata = $urandom;
        tick();
        rst_a = s;
        rst_b = !s;
        instr_valid = 1'b0;
        m_pc   = s ? 32'hFFFF_FFFC : 32'h0;
        m_ir   = 32'h0;
        m_ret  = 32'h0;
        m_halt = 1'b0;
        chk("rst_pc", o_pc, m_pc);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_ir_valid", {31'd0, o_irv}, 32'd0);
        chk("rst_halted", {31'd0, o_hlt}, 32'd0);
        chk("rst_retired", o_ret, 32'd0);
        chk("rst_instr_req", {31'd0, o_req}, 32'd1);
        $display("reset inst=%0d pc=%h", s, o_pc);
    endtask

    // Fetch one word after 'waits' cycles with instr_valid low. EXEC-only
    // inputs are randomized meanwhile to show they are ignored in FETCH.
    task automatic fetch(input logic [31:0] word, input int waits);
        for (int i = 0; i < waits; i++) begin
            instr_valid = 1'b0;
            instr_rdata = $urandom;
            PCWre = 1'($urandom); PCSrc = 1'($urandom); Jump = 1'($urandom);
            imm = 16'($urandom);
            chk("wait_req", {31'd0, o_req}, 32'd1);
            chk("wait_addr", o_addr, m_pc);
            chk("wait_ir_valid", {31'd0, o_irv}, 32'd0);
            chk("wait_instr", o_instr, m_ir);
            tick();
        end
        chk("fetch_req", {31'd0, o_req}, 32'd1);
        chk("fetch_addr", o_addr, m_pc);
        instr_valid = 1'b1;
        instr_rdata = word;
        tick();
        // Garbage responses during EXEC must not reach the IR.
        instr_valid = 1'($urandom);
        instr_rdata = $urandom;
        m_ir = word;
        chk("exec_ir_valid", {31'd0, o_irv}, 32'd1);
        chk("exec_instr", o_instr, word);
        chk("exec_op", {26'd0, o_op}, {26'd0, word[31:26]});
        chk("exec_req", {31'd0, o_req}, 32'd0);
    endtask

    task automatic exec(input bit wre, input bit src, input logic [15:0] im, input bit jmp);
        PCWre = wre; PCSrc = src; imm = im; Jump = jmp;
        tick();
        instr_valid = 1'b0;
        PCWre = 1'($urandom); PCSrc = 1'($urandom); Jump = 1'($urandom);
        if (wre) begin
            m_pc  = model_next(m_pc, m_ir, src, im, jmp);
            m_ret = m_ret + 32'd1;
        end else begin
            m_halt = 1'b1;
        end
        chk("post_pc", o_pc, m_pc);
        chk("post_addr", o_addr, m_pc);
        chk("post_retired", o_ret, m_ret);
        chk("post_halted", {31'd0, o_hlt}, {31'd0, m_halt});
        chk("post_ir_valid", {31'd0, o_irv}, 32'd0);
        chk("post_req", {31'd0, o_req}, {31'd0, !m_halt});
        chk("post_instr", o_instr, m_ir);
        $display("instr ir=%h wre=%0d src=%0d imm=%h jmp=%0d -> pc=%h ret=%0d halted=%0d",
                 m_ir, wre, src, im, jmp, o_pc, o_ret, o_hlt);
    endtask

    task automatic hold_halted(input int n);
        for (int i = 0; i < n; i++) begin
            instr_valid = 1'b1;
            instr_rdata = $urandom;
            PCWre = 1'b1; PCSrc = 1'($urandom); imm = 16'($urandom);
            tick();
            chk("halt_halted", {31'd0, o_hlt}, 32'd1);
            chk("halt_pc", o_pc, m_pc);
            chk("halt_instr", o_instr, m_ir);
            chk("halt_retired", o_ret, m_ret);
            chk("halt_req", {31'd0, o_req}, 32'd0);
            chk("halt_ir_valid", {31'd0, o_irv}, 32'd0);
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        instr_valid = 1'b0; instr_rdata = 32'h0;
        PCWre = 1'b0; PCSrc = 1'b0; imm = 16'h0; Jump = 1'b0;
        tick();

        // Sequential zero-wait execution: addresses 0, 4, 8.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch($urandom, 0);
            exec(1'b1, 1'b0, 16'($urandom), 1'b0);
        end
        chk("seq_retired3", o_ret, 32'd3);
        chk("seq_pc12", o_pc, 32'd12);

        // Backward branch from PC=8, forward branch from PC=8.
        do_reset(1'b0);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        fetch($urandom, 0); exec(1'b1, 1'b1, 16'hFFFE, 1'b0);
        chk("branch_back", o_addr, 32'd4);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        fetch($urandom, 0); exec(1'b1, 1'b1, 16'h0003, 1'b0);
        chk("branch_fwd", o_addr, 32'd24);

        // Wait states, then halt at PC=12.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            fetch($urandom, 3);
            exec(1'b1, 1'b0, 16'h0, 1'b0);
        end
        fetch({6'b111111, 26'($urandom)}, 1);
        exec(1'b0, 1'b1, 16'h0004, 1'b1);
        chk("halt_pc12", o_pc, 32'd12);
        chk("halt_ret3", o_ret, 32'd3);
        hold_halted(4);
        do_reset(1'b0);
        chk("unhalt_pc0", o_pc, 32'd0);

        // Jump behaviour depends on the build.
`ifdef FETCH_JUMP_EN
        fetch({6'h02, 26'h3FF_FFFF}, 0); exec(1'b1, 1'b0, 16'h0, 1'b1);
        chk("jump_far", o_addr, 32'h0FFF_FFFC);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        chk("jump_region", o_addr, 32'h1000_0000);
        fetch({6'h02, 26'h000_0040}, 0); exec(1'b1, 1'b1, 16'h0007, 1'b1);
        chk("jump_prio", o_addr, 32'h1000_0100);
        chk("jump_retired", o_ret, 32'd3);
`else
        fetch({6'h02, 26'h000_0040}, 0); exec(1'b1, 1'b0, 16'h0, 1'b1);
        chk("jump_ignored", o_addr, 32'd4);
`endif

        // Wrapping reset PC and reset during a wait.
        do_reset(1'b1);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        chk("wrap_addr0", o_addr, 32'd0);
        fetch($urandom, 0); exec(1'b1, 1'b0, 16'h0, 1'b0);
        instr_valid = 1'b0;
        tick(); tick();
        chk("midwait_addr", o_addr, 32'd4);
        rst_b = 1'b1;
        instr_valid = 1'b1;
        instr_rdata = 32'hDEAD_BEEF;
        tick();
        rst_b = 1'b0;
        instr_valid = 1'b0;
        m_pc = 32'hFFFF_FFFC; m_ir = 32'h0; m_ret = 32'h0; m_halt = 1'b0;
        chk("midrst_instr", o_instr, 32'h0);
        chk("midrst_addr", o_addr, 32'hFFFF_FFFC);
        chk("midrst_req", {31'd0, o_req}, 32'd1);
        chk("midrst_ir_valid", {31'd0, o_irv}, 32'd0);
        chk("midrst_retired", o_ret, 32'd0);
        fetch($urandom, 1); exec(1'b1, 1'b0, 16'h0, 1'b0);

        // Randomized run against the model, ending in a halt.
        do_reset(1'b0);
        for (int i = 0; i < 250; i++) begin
            fetch($urandom, int'($urandom_range(0, 2)));
            exec(1'b1, 1'($urandom), 16'($urandom), 1'($urandom));
        end
        fetch($urandom, int'($urandom_range(0, 2)));
        exec(1'b0, 1'($urandom), 16'($urandom), 1'($urandom));
        hold_halted(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer that sits on the far side of the control unit's PC interface. It presents the instruction address, latches the returned instruction, and hands the opcode to the control unit. It then consumes the control unit's `PCWre`/`PCSrc` decisions to compute the next PC or halt. Together with the control unit it closes the fetch/decode/next-PC loop of the CPU.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] are forced to 0.

Ports:
- `CLK`  in  1  system clock. All state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `instr_req`  out  1  fetch request to instruction memory.
- `instr_addr`  out  32  fetch address; equals `pc`.
- `instr_rdata`  in  32  instruction word from memory.
- `instr_valid`  in  1  `instr_rdata` is valid. Sampled only in FETCH.
- `instr`  out  32  latched instruction register (IR).
- `op`  out  6  `instr[31:26]`, fed to the control unit.
- `ir_valid`  out  1  high for exactly the EXEC cycle; control-unit outputs are sampled at the end of that cycle.
- `PCWre`  in  1  from control unit. 0 means halt.
- `PCSrc`  in  1  from control unit. 1 means take branch (zero already folded in).
- `imm`  in  16  branch offset, `instr[15:0]` as routed through the datapath.
- `Jump`  in  1  jump request. Used only when FETCH_JUMP_EN is defined; ignored otherwise.
- `pc`  out  32  current PC.
- `halted`  out  1  sticky halt indication.
- `retired`  out  32  count of instructions that completed with `PCWre`=1.

## Operation
States:
- FETCH: `instr_req`=1.
  - `instr_valid`=1: IR <= `instr_rdata`, go to EXEC.
  - `instr_valid`=0: stay in FETCH; `instr_addr` is held stable.
- EXEC: `ir_valid`=1, `instr_req`=0.
  - `PCWre`=0: go to HALT. PC and `retired` are unchanged.
  - `PCWre`=1: PC <= next PC, `retired` <= `retired`+1, go to FETCH.
- HALT: `halted`=1, `instr_req`=0, `ir_valid`=0. Only `Reset` leaves this state.

Next-PC rule:
- `PCSrc`=0: PC+4.
- `PCSrc`=1: PC + 4 + (sign_extend(`imm`) << 2).

Arithmetic rules:
- All PC arithmetic is 32-bit and wraps modulo 2^32. For example, 32'hFFFF_FFFC + 4 = 0.
- PC[1:0] is always 0.
- `retired` wraps from 32'hFFFF_FFFF to 0.

Boundary behaviour:
- `instr_valid` outside FETCH is ignored and does not change IR.
- `PCWre`, `PCSrc`, `imm` and `Jump` are ignored outside EXEC.
- `Reset` has priority over all other events in any state, including mid-fetch wait and HALT.
  - An outstanding fetch is abandoned. A memory response arriving on the reset cycle is discarded.

Reset values:
- State FETCH, `pc`=`RESET_PC`, `instr`=0, `ir_valid`=0, `halted`=0, `retired`=0.
- `instr_req`=1 from the first cycle after the reset edge.

## Timing
- `instr_req`, `instr_addr`, `ir_valid` and `halted` are decoded from registered state and PC only. There is no combinational path from any input to these outputs.
- `op`/`instr` are valid from the cycle after the `instr_valid` acceptance edge and are held through EXEC.
- Zero-wait memory (`instr_valid` high in the same cycle as `instr_req`) gives 2 cycles per instruction. Each wait cycle adds one.
- PC update and `retired` increment occur on the edge that ends EXEC. The new `instr_addr` is presented on the next cycle.
- `halted` rises on the cycle after the EXEC cycle that saw `PCWre`=0.

## Configuration
- `FETCH_JUMP_EN` defined:
  - In EXEC with `PCWre`=1 and `Jump`=1, PC <= {(PC+4)[31:28], `instr`[25:0], 2'b00}.
  - `Jump` has priority over `PCSrc`.
  - The instruction counts as retired.
- `FETCH_JUMP_EN` undefined: the `Jump` port exists but is ignored, and only the two-way next-PC rule applies.

## Test plan
- Reset, then zero-wait memory with `PCWre`=1, `PCSrc`=0 for 3 instructions -> `instr_addr` sequence 0, 4, 8; `ir_valid` every second cycle; `retired`=3.
- Branch at PC=8 with `imm`=16'hFFFE, `PCSrc`=1 -> next `instr_addr`=4. With `imm`=16'h0003 -> next `instr_addr`=24.
- Hold `instr_valid`=0 for 3 cycles in FETCH -> `instr_addr` stable, `ir_valid`=0; on acceptance, IR equals the `instr_rdata` driven on that cycle.
- EXEC with `PCWre`=0 (op 6'b111111) at PC=12 -> `halted`=1 next cycle, `pc` stays 12, `retired` unchanged, further `instr_valid` ignored; `Reset` -> `pc`=0, `halted`=0.
- `RESET_PC`=32'hFFFF_FFFC, one sequential instruction -> next `instr_addr`=0. `Reset` asserted mid-wait -> late `instr_valid` discarded, `instr_addr`=`RESET_PC`.
- FETCH_JUMP_EN defined: PC=32'h1000_0000, `instr`[25:0]=26'h0000040, `Jump`=1, `PCSrc`=1 -> next `instr_addr`=32'h1000_0100.
